apb_master_bridge: RTL and testbench

APB initiator that turns single-beat read/write requests from the CPU-side peripheral bus into APB transfers for the 8-bit peripheral slaves (CONFREG interrupt controller, timer, UART, I2C, SPI, etc.). It decodes a slave index from the request address, drives the IDLE/SETUP/ACCESS phases, waits on `pready`, and returns read data or an error through a valid/ready response channel. There is one outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_slv_mux.sv | 25 ++
 rtl/apb_master_bridge.sv | 197 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM encoding, bus widths and
// the slave-index field of the request address.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_AW     = 20;
    localparam int APB_DW     = 8;
    localparam int SLV_IDX_HI = 23;
    localparam int SLV_IDX_LO = 20;

    function automatic logic [3:0] slv_idx(input logic [23:0] addr);
        return addr[SLV_IDX_HI:SLV_IDX_LO];
    endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Selects one slave's read data and ready by index; an index with no slave
// yields zero data and ready low.
module apb_slv_mux
    import apb_pkg::*;
#(
    parameter int NSLV = 8
) (
    input  logic [3:0]             idx,
    input  logic [NSLV*APB_DW-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    output logic [APB_DW-1:0]      sel_rdata,
    output logic                   sel_ready
);

    // AND-OR selection keeps the mux free of priority logic
    always_comb begin
        sel_rdata = 8'd0;
        sel_ready = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | (prdata[APB_DW*i +: APB_DW] & {APB_DW{idx == 4'(i)}});
            sel_ready = sel_ready | (pready[i] & (idx == 4'(i)));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator for 8-bit peripheral slaves.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int NSLV    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   apb_pclk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [23:0]            req_addr,
    input  logic [7:0]             req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic [NSLV-1:0]        apb_psel,
    output logic                   apb_penable,
    output logic                   apb_pwrite,
    output logic [19:0]            apb_paddr,
    output logic [7:0]             apb_pwdata,
    input  logic [NSLV*8-1:0]      apb_prdata,
    input  logic [NSLV-1:0]        apb_pready
);

    apb_state_e          state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [NSLV-1:0]     psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [APB_AW-1:0]   paddr_q, paddr_d;
    logic [APB_DW-1:0]   pwdata_q, pwdata_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
`ifdef APB_TIMEOUT_EN
    logic [7:0]          cnt_q, cnt_d;
`endif

    logic [3:0]          req_idx_s;
    logic                idx_ok_s;
    logic [APB_DW-1:0]   sel_rdata_s;
    logic                sel_ready_s;

    assign req_idx_s = slv_idx(req_addr);
    assign idx_ok_s  = ({1'b0, req_idx_s} < 5'(NSLV));

    apb_slv_mux #(.NSLV(NSLV)) u_slv_mux (
        .idx       (idx_q),
        .prdata    (apb_prdata),
        .pready    (apb_pready),
        .sel_rdata (sel_rdata_s),
        .sel_ready (sel_ready_s)
    );

    // Next-state and next-output computation; all outputs come from flops
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (idx_ok_s) begin
                        state_d  = ST_SETUP;
                        idx_d    = req_idx_s;
                        pwrite_d = req_write;
                        paddr_d  = req_addr[APB_AW-1:0];
                        pwdata_d = req_wdata;
                        for (int i = 0; i < NSLV; i++) begin
                            psel_d[i] = (req_idx_s == 4'(i));
                        end
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 8'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = 8'd0;
`endif
            end
            ST_ACCESS: begin
                // pready has priority over a timeout in the same cycle
                if (sel_ready_s) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? 8'd0 : sel_rdata_s;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                else begin
                    state_d = ST_ACCESS;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                psel_d      = '0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge apb_pclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 20'd0;
            pwdata_q    <= 8'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (NSLV=8, TIMEOUT=4).
module tb_apb_master_bridge;

    localparam int NSLV = 8;

    logic              apb_pclk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [23:0]       req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic [NSLV-1:0]   apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [19:0]       apb_paddr;
    logic [7:0]        apb_pwdata;
    logic [NSLV*8-1:0] apb_prdata;
    logic [NSLV-1:0]   apb_pready;

    int total = 0;
    int bad   = 0;

    apb_master_bridge #(.NSLV(NSLV), .TIMEOUT(4)) dut (
        .apb_pclk    (apb_pclk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready)
    );

    always #5 apb_pclk = ~apb_pclk;

    task automatic tick();
        @(posedge apb_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request and advances past the accepting edge T into cycle T+1
    task automatic send(input logic w, input logic [23:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 24'd0;
        req_wdata  = 8'd0;
        rsp_ready  = 1'b1;
        apb_pready = 8'hFF;
        apb_prdata = 64'h8877_6655_3C22_1100;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_psel", 32'(apb_psel), 32'd0);
        chk("rst_penable", 32'(apb_penable), 32'd0);
        chk("rst_paddr", 32'(apb_paddr), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait write to slave 0
        send(1'b1, 24'h000004, 8'hA5);
        req_valid = 1'b0;
        chk("w_setup_psel", 32'(apb_psel), 32'h01);
        chk("w_setup_penable", 32'(apb_penable), 32'd0);
        chk("w_setup_pwdata", 32'(apb_pwdata), 32'hA5);
        chk("w_setup_paddr", 32'(apb_paddr), 32'h00004);
        chk("w_setup_pwrite", 32'(apb_pwrite), 32'd1);
        chk("w_setup_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("w_access_psel", 32'(apb_psel), 32'h01);
        chk("w_access_penable", 32'(apb_penable), 32'd1);
        tick();
        chk("w_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w_rsp_err", 32'(rsp_err), 32'd0);
        chk("w_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("w_rsp_psel", 32'(apb_psel), 32'd0);
        chk("w_rsp_penable", 32'(apb_penable), 32'd0);
        tick();
        chk("w_idle_req_ready", 32'(req_ready), 32'd1);
        chk("w_idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Read from slave 3 with two wait cycles
        apb_pready = 8'hF7;
        send(1'b0, 24'h300010, 8'h00);
        req_valid = 1'b0;
        chk("r_setup_psel", 32'(apb_psel), 32'h08);
        chk("r_setup_penable", 32'(apb_penable), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) apb_pready = 8'hFF;
            chk($sformatf("r_access%0d_psel", c), 32'(apb_psel), 32'h08);
            chk($sformatf("r_access%0d_penable", c), 32'(apb_penable), 32'd1);
            chk($sformatf("r_access%0d_paddr", c), 32'(apb_paddr), 32'h00010);
            chk($sformatf("r_access%0d_pwrite", c), 32'(apb_pwrite), 32'd0);
            chk($sformatf("r_access%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_rsp_rdata", 32'(rsp_rdata), 32'h3C);
        chk("r_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Unmapped slave index 0xF
        send(1'b0, 24'hF00000, 8'h00);
        req_valid = 1'b0;
        chk("u_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("u_rsp_err", 32'(rsp_err), 32'd1);
        chk("u_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("u_psel", 32'(apb_psel), 32'd0);
        chk("u_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("u_idle_req_ready", 32'(req_ready), 32'd1);

        // Response back-pressure with a second request pending
        rsp_ready = 1'b0;
        send(1'b1, 24'h100020, 8'h5A);
        req_write = 1'b0;
        req_addr  = 24'h200008;
        req_wdata = 8'hEE;
        tick();
        chk("bp_access_pwdata", 32'(apb_pwdata), 32'h5A);
        chk("bp_access_psel", 32'(apb_psel), 32'h02);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_err", c), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d_rsp_rdata", c), 32'(rsp_rdata), 32'd0);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_psel", c), 32'(apb_psel), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_exit_req_ready", 32'(req_ready), 32'd1);
        chk("bp_exit_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_exit_psel", 32'(apb_psel), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("bp2_setup_psel", 32'(apb_psel), 32'h04);
        chk("bp2_setup_paddr", 32'(apb_paddr), 32'h00008);
        chk("bp2_setup_pwrite", 32'(apb_pwrite), 32'd0);
        tick();
        tick();
        chk("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp2_rsp_rdata", 32'(rsp_rdata), 32'h22);
        tick();

        // Slave 4 never ready
        apb_pready = 8'hEF;
        send(1'b0, 24'h400000, 8'h00);
        req_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("to_access%0d_penable", c), 32'(apb_penable), 32'd1);
        end
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("to_psel", 32'(apb_psel), 32'd0);
        tick();
`else
        for (int c = 0; c < 300; c++) begin
            tick();
        end
        chk("stuck_penable", 32'(apb_penable), 32'd1);
        chk("stuck_psel", 32'(apb_psel), 32'h10);
        chk("stuck_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        // Reset during ACCESS
        apb_pready = 8'hDF;
        send(1'b1, 24'h500040, 8'h33);
        req_valid = 1'b0;
        tick();
        chk("ra_penable", 32'(apb_penable), 32'd1);
        chk("ra_psel", 32'(apb_psel), 32'h20);
        rst = 1'b1;
        tick();
        chk("ra_rst_psel", 32'(apb_psel), 32'd0);
        chk("ra_rst_penable", 32'(apb_penable), 32'd0);
        chk("ra_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ra_rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        apb_pready = 8'hFF;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
